// File: rtl/ring_evt_buf_pkg.sv
// Shared types and constants for the ring event buffer: FSM state encoding,
// default parameter values and L1A queue entry field widths.
// Ports: none (package).
package ring_evt_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } evt_state_t;

  localparam int DEF_DATA_W   = 18;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_Q_DEPTH  = 16;
  localparam int DEF_WARN_LVL = 3328;

  // L1A queue entry = {event start pointer (ADDR_W+1), L1A number}
  localparam int L1A_NUM_W = 24;
  localparam int SAMP_W    = 7;

  function automatic int q_entry_w(input int addr_w);
    return addr_w + 1 + L1A_NUM_W;
  endfunction

endpackage

// File: rtl/ring_l1a_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO holding queued L1A entries.
// Latency: pushed word visible on pop_dat the cycle after push; pop takes effect next edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk/rst (async active-high), push/push_dat, pop/pop_dat (head word), full, empty.
module ring_l1a_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    // Extra MSB distinguishes full from empty when the index bits match.
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  assign pop_dat = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ring_evt_buf.sv
// Purpose: sample ring buffer; each L1A queues a start pointer and the event is read out.
// Latency: EVT_PUSH one cycle after LOAD; sample read issued at t appears on RDATA at t+2.
// Backpressure: EVT_BUF_AFL stops loads and new reads; two in-flight reads still emerge.
// Ports: CLK, RST_RESYNC (async active-high); write side WREN/WDATA; trigger L1A/L1A_NUM
//        with PRE_TRIG/SAMP_MAX; outputs EVT_PUSH/EVT_L1A_NUM/EVT_OVFL header,
//        DATA_PUSH/RDATA/RD_LAST samples, L1A_OVFL drop pulse, WARN and sticky RING_ERR.
module ring_evt_buf
  import ring_evt_buf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int Q_DEPTH  = DEF_Q_DEPTH,
  parameter int WARN_LVL = DEF_WARN_LVL
) (
  input  logic                 CLK,
  input  logic                 RST_RESYNC,
  input  logic                 WREN,
  input  logic [DATA_W-1:0]    WDATA,
  input  logic                 L1A,
  input  logic [L1A_NUM_W-1:0] L1A_NUM,
  input  logic [ADDR_W-1:0]    PRE_TRIG,
  input  logic [SAMP_W-1:0]    SAMP_MAX,
  input  logic                 EVT_BUF_AFL,
  output logic                 EVT_PUSH,
  output logic [L1A_NUM_W-1:0] EVT_L1A_NUM,
  output logic                 EVT_OVFL,
  output logic [DATA_W-1:0]    RDATA,
  output logic                 DATA_PUSH,
  output logic                 RD_LAST,
  output logic                 L1A_OVFL,
  output logic                 WARN,
  output logic                 RING_ERR
);

  localparam int PW    = ADDR_W + 1;
  localparam int QW    = q_entry_w(ADDR_W);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [PW-1:0] WARN_THR = PW'(WARN_LVL);

  // Ring storage: simple dual-port, registered read, never reset.
  logic [DATA_W-1:0] ring_mem [DEPTH];
  logic [DATA_W-1:0] ram_dout_q;

  evt_state_t state_q, state_d;

  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [SAMP_W-1:0]    samp_max_q, samp_max_d;
  logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d;
  logic                 evt_push_q, evt_push_d;
  logic [L1A_NUM_W-1:0] evt_num_q, evt_num_d;
  logic                 evt_ovfl_q, evt_ovfl_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 rd_last1_q, rd_last1_d;
  logic                 data_push_q, data_push_d;
  logic                 rd_last_q, rd_last_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 l1a_ovfl_q, l1a_ovfl_d;
  logic                 ring_err_q, ring_err_d;

  // L1A queue signals
  logic          q_push, q_pop, q_full, q_empty;
  logic [QW-1:0] q_wdat, q_rdat;
  logic [PW-1:0] head_start;
  logic [PW-1:0] head_occ, oldest, occ;

  // FSM outputs
  logic rd_issue, rd_last_iss;

  assign head_start = q_rdat[QW-1 -: PW];

  ring_l1a_fifo #(
    .WIDTH (QW),
    .DEPTH (Q_DEPTH)
  ) u_l1a_fifo (
    .clk      (CLK),
    .rst      (RST_RESYNC),
    .push     (q_push),
    .push_dat (q_wdat),
    .pop      (q_pop),
    .pop_dat  (q_rdat),
    .full     (q_full),
    .empty    (q_empty)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!q_empty && !EVT_BUF_AFL) state_d = ST_LOAD;
      // SAMP_MAX sampled here is the value latched for this event.
      ST_LOAD: state_d = (SAMP_MAX == '0) ? ST_IDLE : ST_READ;
      ST_READ: if (rd_last_iss) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    q_pop       = 1'b0;
    rd_issue    = 1'b0;
    rd_last_iss = 1'b0;
    case (state_q)
      ST_LOAD: q_pop = 1'b1;
      ST_READ: begin
        // rptr != wptr guarantees the sample has already been written.
        if (!EVT_BUF_AFL && (rptr_q != wptr_q)) begin
          rd_issue    = 1'b1;
          rd_last_iss = (samp_cnt_q == samp_max_q - SAMP_W'(1));
        end
      end
      default: ;
    endcase
  end

  // ---------------- Datapath ----------------
  always_comb begin
    wptr_d = wptr_q;
    if (WREN) wptr_d = wptr_q + PW'(1);

    // Enqueue with the pre-increment write pointer; a pop in the same cycle frees a slot.
    q_wdat     = {wptr_q - {1'b0, PRE_TRIG}, L1A_NUM};
    q_push     = L1A && (!q_full || q_pop);
    l1a_ovfl_d = L1A && q_full && !q_pop;

    head_occ = wptr_q - head_start;
    if (state_q == ST_READ) oldest = rptr_q;
    else if (!q_empty)      oldest = head_start;
    else                    oldest = wptr_q;
    occ = wptr_q - oldest;
    // Occupancy above depth-1 is exactly the MSB of the modular difference.
    ring_err_d = ring_err_q | occ[ADDR_W];

    rptr_d     = rptr_q;
    samp_max_d = samp_max_q;
    samp_cnt_d = samp_cnt_q;
    evt_push_d = 1'b0;
    evt_num_d  = evt_num_q;
    evt_ovfl_d = 1'b0;
    if (state_q == ST_LOAD) begin
      rptr_d     = head_start;
      samp_max_d = SAMP_MAX;
      samp_cnt_d = '0;
      evt_push_d = 1'b1;
      evt_num_d  = q_rdat[L1A_NUM_W-1:0];
      evt_ovfl_d = head_occ[ADDR_W];
    end else if (rd_issue) begin
      rptr_d     = rptr_q + PW'(1);
      samp_cnt_d = samp_cnt_q + SAMP_W'(1);
    end

    // Two-stage read pipe: RAM output register, then output register.
    rd_vld_d    = rd_issue;
    rd_last1_d  = rd_last_iss;
    data_push_d = rd_vld_q;
    rd_last_d   = rd_last1_q;
    rdata_d     = rd_vld_q ? ram_dout_q : rdata_q;
  end

  always_ff @(posedge CLK) begin
    if (WREN)     ring_mem[wptr_q[ADDR_W-1:0]] <= WDATA;
    if (rd_issue) ram_dout_q <= ring_mem[rptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge CLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      samp_max_q  <= '0;
      samp_cnt_q  <= '0;
      evt_push_q  <= 1'b0;
      evt_num_q   <= '0;
      evt_ovfl_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last1_q  <= 1'b0;
      data_push_q <= 1'b0;
      rd_last_q   <= 1'b0;
      rdata_q     <= '0;
      l1a_ovfl_q  <= 1'b0;
      ring_err_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      samp_max_q  <= samp_max_d;
      samp_cnt_q  <= samp_cnt_d;
      evt_push_q  <= evt_push_d;
      evt_num_q   <= evt_num_d;
      evt_ovfl_q  <= evt_ovfl_d;
      rd_vld_q    <= rd_vld_d;
      rd_last1_q  <= rd_last1_d;
      data_push_q <= data_push_d;
      rd_last_q   <= rd_last_d;
      rdata_q     <= rdata_d;
      l1a_ovfl_q  <= l1a_ovfl_d;
      ring_err_q  <= ring_err_d;
    end
  end

  assign EVT_PUSH    = evt_push_q;
  assign EVT_L1A_NUM = evt_num_q;
  assign EVT_OVFL    = evt_ovfl_q;
  assign RDATA       = rdata_q;
  assign DATA_PUSH   = data_push_q;
  assign RD_LAST     = rd_last_q;
  assign L1A_OVFL    = l1a_ovfl_q;
  assign WARN        = (occ >= WARN_THR);
  assign RING_ERR    = ring_err_q;

endmodule
